// File: rtl/register_file.sv
// Register file with registered read ports: one write port, two read ports, same-cycle
// write bypass, and stall hold / flush bubble on the outputs.
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rs_data_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [ADDR_W-1:0] rs_addr_out,
  output logic [ADDR_W-1:0] rt_addr_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;

  logic              wr_ok;
  logic [DATA_W-1:0] rs_rd_val;
  logic [DATA_W-1:0] rt_rd_val;

  // Writes to index 0 are dropped, which also keeps index 0 out of the bypass.
  assign wr_ok = reg_write_in && (rd_in != '0);

  // Read values for the incoming indices, with the in-flight write forwarded.
  always_comb begin
    rs_rd_val = '0;
    rt_rd_val = '0;
    if (rs_addr != '0) begin
      rs_rd_val = (wr_ok && (rd_in == rs_addr)) ? wb_data_in : mem_q[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_rd_val = (wr_ok && (rd_in == rt_addr)) ? wb_data_in : mem_q[rt_addr];
    end
  end

  // Next-state for storage and output latch; reset, then flush, then stall, then capture.
  always_comb begin
    mem_d     = mem_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;

    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      rs_data_d = '0;
      rt_data_d = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
    end else begin
      if (wr_ok) begin
        mem_d[rd_in] = wb_data_in;
      end

      if (flush) begin
        rs_data_d = '0;
        rt_data_d = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
      end else if (stall) begin
        // Held operands pick up a write that targets the held index.
        if (wr_ok && (rd_in == rs_addr_q)) begin
          rs_data_d = wb_data_in;
        end
        if (wr_ok && (rd_in == rt_addr_q)) begin
          rt_data_d = wb_data_in;
        end
      end else begin
        rs_data_d = rs_rd_val;
        rt_data_d = rt_rd_val;
        rs_addr_d = rs_addr;
        rt_addr_d = rt_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    rs_data_q <= rs_data_d;
    rt_data_q <= rt_data_d;
    rs_addr_q <= rs_addr_d;
    rt_addr_q <= rt_addr_d;
  end

  assign rs_data_out = rs_data_q;
  assign rt_data_out = rt_data_q;
  assign rs_addr_out = rs_addr_q;
  assign rt_addr_out = rt_addr_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: one task per scenario.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        reg_write_in;
  logic [4:0]  rd_in;
  logic [31:0] wb_data_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        stall;
  logic        flush;
  logic [31:0] rs_data_out;
  logic [31:0] rt_data_out;
  logic [4:0]  rs_addr_out;
  logic [4:0]  rt_addr_out;

  int checks   = 0;
  int failures = 0;

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .reg_write_in (reg_write_in),
    .rd_in        (rd_in),
    .wb_data_in   (wb_data_in),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .stall        (stall),
    .flush        (flush),
    .rs_data_out  (rs_data_out),
    .rt_data_out  (rt_data_out),
    .rs_addr_out  (rs_addr_out),
    .rt_addr_out  (rt_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset        = 1'b1;
    reg_write_in = 1'b0;
    rd_in        = 5'd0;
    wb_data_in   = 32'd0;
    stall        = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0; rs_addr = 5'd3; rt_addr = 5'd4;
    reg_write_in = 1'b1; rd_in = 5'd3; wb_data_in = 32'hCAFE0000;
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL reset_rs_data got=%h exp=%h", rs_data_out, 32'd0); end
    checks++; if (rt_data_out !== 32'd0) begin failures++; $display("FAIL reset_rt_data got=%h exp=%h", rt_data_out, 32'd0); end
    checks++; if (rs_addr_out !== 5'd0) begin failures++; $display("FAIL reset_rs_addr got=%0d exp=0", rs_addr_out); end
    checks++; if (rt_addr_out !== 5'd0) begin failures++; $display("FAIL reset_rt_addr got=%0d exp=0", rt_addr_out); end
    idle();
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL reset_write_dropped got=%h exp=%h", rs_data_out, 32'd0); end
  endtask

  task automatic test_write_read();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd5; wb_data_in = 32'hDEADBEEF; rs_addr = 5'd1; rt_addr = 5'd2;
    step();
    idle();
    rs_addr = 5'd5; rt_addr = 5'd0;
    step();
    checks++; if (rs_data_out !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_rs_data got=%h exp=%h", rs_data_out, 32'hDEADBEEF); end
    checks++; if (rs_addr_out !== 5'd5) begin failures++; $display("FAIL wr_rd_rs_addr got=%0d exp=5", rs_addr_out); end
    checks++; if (rt_data_out !== 32'd0) begin failures++; $display("FAIL wr_rd_rt_zero got=%h exp=%h", rt_data_out, 32'd0); end
  endtask

  task automatic test_bypass();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd7; wb_data_in = 32'h12345678; rs_addr = 5'd7; rt_addr = 5'd7;
    step();
    checks++; if (rs_data_out !== 32'h12345678) begin failures++; $display("FAIL bypass_rs got=%h exp=%h", rs_data_out, 32'h12345678); end
    checks++; if (rt_data_out !== 32'h12345678) begin failures++; $display("FAIL bypass_rt got=%h exp=%h", rt_data_out, 32'h12345678); end
    checks++; if (rt_addr_out !== 5'd7) begin failures++; $display("FAIL bypass_rt_addr got=%0d exp=7", rt_addr_out); end
  endtask

  task automatic test_r0();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd0; wb_data_in = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd7;
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL r0_bypass got=%h exp=%h", rs_data_out, 32'd0); end
    idle();
    rs_addr = 5'd0;
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL r0_read got=%h exp=%h", rs_data_out, 32'd0); end
    checks++; if (rt_data_out !== 32'h12345678) begin failures++; $display("FAIL r0_rt_r7 got=%h exp=%h", rt_data_out, 32'h12345678); end
  endtask

  task automatic test_different_index();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd8; wb_data_in = 32'h00000080;
    step();
    reg_write_in = 1'b1; rd_in = 5'd8; wb_data_in = 32'h00000888; rs_addr = 5'd5; rt_addr = 5'd11;
    step();
    checks++; if (rs_data_out !== 32'hDEADBEEF) begin failures++; $display("FAIL diff_idx_old got=%h exp=%h", rs_data_out, 32'hDEADBEEF); end
    checks++; if (rt_data_out !== 32'd0) begin failures++; $display("FAIL diff_idx_r11 got=%h exp=%h", rt_data_out, 32'd0); end
    idle();
    rs_addr = 5'd8;
    step();
    checks++; if (rs_data_out !== 32'h00000888) begin failures++; $display("FAIL diff_idx_r8 got=%h exp=%h", rs_data_out, 32'h00000888); end
  endtask

  task automatic test_stall();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd3; wb_data_in = 32'h11;
    step();
    idle();
    rs_addr = 5'd3; rt_addr = 5'd3;
    step();
    checks++; if (rs_data_out !== 32'h11) begin failures++; $display("FAIL stall_capture got=%h exp=%h", rs_data_out, 32'h11); end
    // stall cycle 1: inputs move, outputs hold
    stall = 1'b1; rs_addr = 5'd6; rt_addr = 5'd5;
    step();
    checks++; if (rs_data_out !== 32'h11) begin failures++; $display("FAIL stall_c1_rs got=%h exp=%h", rs_data_out, 32'h11); end
    checks++; if (rt_data_out !== 32'h11) begin failures++; $display("FAIL stall_c1_rt got=%h exp=%h", rt_data_out, 32'h11); end
    checks++; if (rs_addr_out !== 5'd3) begin failures++; $display("FAIL stall_c1_addr got=%0d exp=3", rs_addr_out); end
    // stall cycle 2: write to held index refreshes both data outputs
    reg_write_in = 1'b1; rd_in = 5'd3; wb_data_in = 32'h22;
    step();
    checks++; if (rs_data_out !== 32'h22) begin failures++; $display("FAIL stall_c2_rs got=%h exp=%h", rs_data_out, 32'h22); end
    checks++; if (rt_data_out !== 32'h22) begin failures++; $display("FAIL stall_c2_rt got=%h exp=%h", rt_data_out, 32'h22); end
    // stall cycle 3: write elsewhere must not disturb held outputs
    rd_in = 5'd6; wb_data_in = 32'h66;
    step();
    checks++; if (rs_data_out !== 32'h22) begin failures++; $display("FAIL stall_c3_rs got=%h exp=%h", rs_data_out, 32'h22); end
    checks++; if (rt_addr_out !== 5'd3) begin failures++; $display("FAIL stall_c3_addr got=%0d exp=3", rt_addr_out); end
    idle();
    step();
    checks++; if (rs_data_out !== 32'h66) begin failures++; $display("FAIL stall_release_rs got=%h exp=%h", rs_data_out, 32'h66); end
    checks++; if (rs_addr_out !== 5'd6) begin failures++; $display("FAIL stall_release_addr got=%0d exp=6", rs_addr_out); end
  endtask

  task automatic test_flush();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd4; wb_data_in = 32'h44;
    step();
    idle();
    rs_addr = 5'd4; rt_addr = 5'd4; stall = 1'b1; flush = 1'b1;
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL flush_rs_data got=%h exp=%h", rs_data_out, 32'd0); end
    checks++; if (rt_data_out !== 32'd0) begin failures++; $display("FAIL flush_rt_data got=%h exp=%h", rt_data_out, 32'd0); end
    checks++; if (rs_addr_out !== 5'd0) begin failures++; $display("FAIL flush_rs_addr got=%0d exp=0", rs_addr_out); end
    checks++; if (rt_addr_out !== 5'd0) begin failures++; $display("FAIL flush_rt_addr got=%0d exp=0", rt_addr_out); end
    idle();
    step();
    checks++; if (rs_data_out !== 32'h44) begin failures++; $display("FAIL flush_storage got=%h exp=%h", rs_data_out, 32'h44); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    reg_write_in = 1'b1; rd_in = 5'd9; wb_data_in = 32'h99;
    step();
    idle();
    rs_addr = 5'd9; rt_addr = 5'd9;
    step();
    checks++; if (rs_data_out !== 32'h99) begin failures++; $display("FAIL rst_mid_pre got=%h exp=%h", rs_data_out, 32'h99); end
    stall = 1'b1; reset = 1'b0;
    reg_write_in = 1'b1; rd_in = 5'd10; wb_data_in = 32'hAA;
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL rst_mid_rs got=%h exp=%h", rs_data_out, 32'd0); end
    checks++; if (rs_addr_out !== 5'd0) begin failures++; $display("FAIL rst_mid_addr got=%0d exp=0", rs_addr_out); end
    idle();
    rs_addr = 5'd9; rt_addr = 5'd10;
    step();
    checks++; if (rs_data_out !== 32'd0) begin failures++; $display("FAIL rst_r9 got=%h exp=%h", rs_data_out, 32'd0); end
    checks++; if (rt_data_out !== 32'd0) begin failures++; $display("FAIL rst_r10 got=%h exp=%h", rt_data_out, 32'd0); end
    checks++; if (rt_addr_out !== 5'd10) begin failures++; $display("FAIL rst_resume_addr got=%0d exp=10", rt_addr_out); end
  endtask

  initial begin
    idle();
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_different_index();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
